sram_ctrl: RTL and testbench
============================

Name: sram_ctrl

Overview:
- Physical memory controller directly downstream of the MMU; consumes its physical-address bus (addr, write data, is_write, busy) and drives one external asynchronous 32-bit SRAM.
- Reads are combinational pass-through, so read data is valid before the next posedge.
- Writes are latched and sequenced as a multi-cycle WE pulse with setup and hold phases; busy is held for the whole sequence.
- Accesses outside the SRAM window are decoded as unmapped.

Parameters:
- BASE_ADDR, 32'h0000_0000: physical byte base of the SRAM window; must be word aligned.
- ADDR_WIDTH, 20: SRAM word-address width. The window covers (1<<ADDR_WIDTH)*4 bytes.
- WE_CYCLES, 2: number of cycles sram_we_n is held low. Legal range is 1..15, using a 4-bit counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- addr  in  32  physical byte address from MMU; bits [1:0] are ignored
- data_in  in  32  write data from MMU; sampled only on the accept edge
- is_write  in  1  write request, sampled in IDLE
- data_out  out  32  read data, combinational
- busy  out  1  controller occupied
- sram_addr  out  ADDR_WIDTH  SRAM word address
- sram_data_out  out  32  data driven toward the SRAM
- sram_data_in  in  32  data from the SRAM
- sram_data_oe  out  1  enables the tristate drivers of sram_data_out
- sram_ce_n  out  1  chip enable, active-low
- sram_oe_n  out  1  output enable, active-low
- sram_we_n  out  1  write enable, active-low

Behaviour:
- Reset: rst and clk are already decided; rst is synchronous and active-high, clk is the clock.
- Reset values: state=IDLE, cnt=0, wr_addr=0, wr_data=0.
  - Registered sram_we_n=1 and sram_data_oe=0 in the cycle after the reset edge.
  - busy follows the combinational rule below (0 unless is_write on a mapped addr).
- Decode: mapped = (addr >= BASE_ADDR) && (addr - BASE_ADDR < (1<<ADDR_WIDTH)*4), 32-bit unsigned compare. Word index = (addr - BASE_ADDR)[ADDR_WIDTH+1:2].
- States: IDLE, WR_SETUP, WR_PULSE, WR_HOLD.
- IDLE:
  - sram_addr = live word index; sram_ce_n = !mapped; sram_oe_n = !mapped; sram_we_n = 1; sram_data_oe = 0.
  - data_out = mapped ? sram_data_in : 0.
  - is_write && mapped at a posedge latches wr_addr and wr_data, then goes to WR_SETUP.
  - is_write && !mapped is silently dropped: no state change, busy stays 0.
- WR_SETUP (1 cycle):
  - sram_addr = wr_addr; sram_data_out = wr_data; sram_data_oe = 1; ce_n = 0; oe_n = 1; we_n = 1; data_out = 0.
  - Loads cnt = WE_CYCLES-1, then goes to WR_PULSE.
- WR_PULSE:
  - Same outputs as WR_SETUP except we_n = 0.
  - cnt==0 goes to WR_HOLD; otherwise cnt decrements.
- WR_HOLD (1 cycle):
  - we_n = 1; data, address and oe still driven from the latches.
  - Goes to IDLE.
- busy = (state != IDLE) || (state == IDLE && is_write && mapped). busy rises combinationally in the request cycle, before the accept edge.
- Write latency: busy high for exactly WE_CYCLES+3 consecutive cycles, counting the request cycle. The default is 5.
- sram_we_n must be registered or derived glitch-free from state; it must never pulse low in IDLE, WR_SETUP or WR_HOLD.
- is_write outside IDLE is ignored (MMU protocol violation). No queuing.
- addr changes during a write have no effect; SRAM signals use the latched wr_addr until IDLE.
- Reset mid-write: the state returns to IDLE at the reset edge and we_n deasserts that edge. The partial write is undefined in SRAM contents but must not hang.
- Back-to-back: a new is_write in the first IDLE cycle after WR_HOLD is accepted normally.

Test Plan:
- Read: SRAM model word 5 = 32'hDEADBEEF; addr = BASE+0x14 with is_write=0 -> sram_addr=5, oe_n=0, ce_n=0, data_out=32'hDEADBEEF, busy=0 in the same cycle.
- Write timing (WE_CYCLES=2): is_write=1 for one cycle, addr=BASE+0x8, data_in=32'h12345678 -> busy high for 5 cycles.
  - Phase sequence: SETUP(we_n=1), PULSE x2(we_n=0), HOLD(we_n=1).
  - sram_addr=2 and data_oe=1 through HOLD.
  - A following read of BASE+0x8 returns 32'h12345678.
- Unmapped (ADDR_WIDTH=4, BASE=0): read of 0x40 -> data_out=0, ce_n=1. Write to 0x40 -> busy stays 0, we_n never low, SRAM model unchanged.
- Address instability: during a write, addr toggles to 0x100 and is_write pulses again -> sram_addr stays at the latched word, no second write, busy duration unchanged at 5.
- Reset mid-write: rst asserted during WR_PULSE -> next cycle state=IDLE, we_n=1, data_oe=0, busy=0. A subsequent write completes normally.
- WE_CYCLES=1 and 15: busy length is 4 and 18 cycles respectively; we_n low for exactly 1 and 15 cycles.

Source files
------------

// File: rtl/sram_ctrl.sv
// Physical memory controller for one external asynchronous 32-bit SRAM.
// Reads pass straight through; writes are latched and sequenced as setup / WE pulse / hold.
module sram_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          ADDR_WIDTH = 20,
  parameter int          WE_CYCLES  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           addr,
  input  logic [31:0]           data_in,
  input  logic                  is_write,
  output logic [31:0]           data_out,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [31:0]           sram_data_out,
  input  logic [31:0]           sram_data_in,
  output logic                  sram_data_oe,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n
);

  // state    | meaning
  // IDLE     | reads pass through, write requests accepted
  // WR_SETUP | address/data driven, WE still high
  // WR_PULSE | WE low for WE_CYCLES cycles
  // WR_HOLD  | WE high again, address/data still driven
  typedef enum logic [1:0] {IDLE, WR_SETUP, WR_PULSE, WR_HOLD} state_t;

  localparam logic [3:0]  CNT_LOAD  = 4'(WE_CYCLES - 1);
  localparam logic [32:0] WIN_BYTES = 33'd1 << (ADDR_WIDTH + 2);

  state_t                state;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;
  logic [31:0]           offset;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  mapped;
  logic                  accept;
  logic                  unused_offset_bits;

  // 33-bit compare so a window of the full 4 GiB does not overflow
  assign offset   = addr - BASE_ADDR;
  assign mapped   = (addr >= BASE_ADDR) && ({1'b0, offset} < WIN_BYTES);
  assign word_idx = offset[ADDR_WIDTH+1:2];
  assign accept   = (state == IDLE) && is_write && mapped;

  assign unused_offset_bits = ^{offset[1:0], offset >> (ADDR_WIDTH + 2)};

  // we_n and data_oe are registered so the SRAM strobe cannot glitch
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      wr_addr      <= '0;
      wr_data      <= 32'd0;
      sram_we_n    <= 1'b1;
      sram_data_oe <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            wr_addr      <= word_idx;
            wr_data      <= data_in;
            sram_data_oe <= 1'b1;
            state        <= WR_SETUP;
          end
        end
        WR_SETUP: begin
          cnt       <= CNT_LOAD;
          sram_we_n <= 1'b0;
          state     <= WR_PULSE;
        end
        WR_PULSE: begin
          if (cnt == 4'd0) begin
            sram_we_n <= 1'b1;
            state     <= WR_HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        WR_HOLD: begin
          sram_data_oe <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          sram_we_n    <= 1'b1;
          sram_data_oe <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    busy          = (state != IDLE) || accept;
    sram_addr     = wr_addr;
    sram_data_out = wr_data;
    sram_ce_n     = 1'b0;
    sram_oe_n     = 1'b1;
    data_out      = 32'd0;
    if (state == IDLE) begin
      sram_addr = word_idx;
      sram_ce_n = !mapped;
      sram_oe_n = !mapped;
      data_out  = mapped ? sram_data_in : 32'd0;
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: three instances (different base / WE width) each with an SRAM device model,
// checked against a word-array reference model.
module tb_sram_ctrl;
  localparam int N  = 3;
  localparam int AW = 4;
  localparam logic [31:0] BASES [N] = '{32'h0, 32'h40, 32'h0};
  localparam int          WES   [N] = '{2, 1, 15};

  logic clk = 1'b0;
  logic rst;
  logic load;
  always #5 clk = ~clk;

  logic [31:0]   addr [N];
  logic [31:0]   data_in [N];
  logic          is_write [N];
  logic [31:0]   data_out [N];
  logic          busy [N];
  logic [AW-1:0] sram_addr [N];
  logic [31:0]   sram_dout [N];
  logic [31:0]   sram_din [N];
  logic          data_oe [N];
  logic          ce_n [N];
  logic          oe_n [N];
  logic          we_n [N];

  logic [31:0] ref_mem [N][16];
  int total = 0;
  int bad = 0;
  int cur_k = 0;

  for (genvar g = 0; g < N; g++) begin : g_inst
    logic [31:0] mem [16];

    sram_ctrl #(.BASE_ADDR(BASES[g]), .ADDR_WIDTH(AW), .WE_CYCLES(WES[g])) dut (
      .clk(clk), .rst(rst), .addr(addr[g]), .data_in(data_in[g]), .is_write(is_write[g]),
      .data_out(data_out[g]), .busy(busy[g]), .sram_addr(sram_addr[g]),
      .sram_data_out(sram_dout[g]), .sram_data_in(sram_din[g]), .sram_data_oe(data_oe[g]),
      .sram_ce_n(ce_n[g]), .sram_oe_n(oe_n[g]), .sram_we_n(we_n[g])
    );

    assign sram_din[g] = mem[sram_addr[g]];

    always @(posedge clk) begin
      if (load) begin
        for (int i = 0; i < 16; i++) mem[i] <= ref_mem[g][i];
      end else if (!ce_n[g] && !we_n[g] && data_oe[g]) begin
        mem[sram_addr[g]] <= sram_dout[g];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d got=%h exp=%h", tag, cur_k, got, exp);
    end
  endtask

  function automatic logic is_mapped(input int k, input logic [31:0] a);
    return (a >= BASES[k]) && ((a - BASES[k]) < 32'd64);
  endfunction

  function automatic logic [3:0] widx(input int k, input logic [31:0] a);
    logic [31:0] o;
    o = (a - BASES[k]) >> 2;
    return o[3:0];
  endfunction

  task automatic do_read(input int k, input logic [31:0] a);
    logic m;
    m = is_mapped(k, a);
    cur_k = k;
    @(negedge clk);
    addr[k] = a;
    is_write[k] = 1'b0;
    #4;
    chk("rd_data", data_out[k], m ? ref_mem[k][widx(k, a)] : 32'h0);
    chk("rd_addr", 32'(sram_addr[k]), 32'(widx(k, a)));
    chk("rd_ce_n", ce_n[k], !m);
    chk("rd_oe_n", oe_n[k], !m);
    chk("rd_busy", busy[k], 0);
    chk("rd_we_n", we_n[k], 1);
    chk("rd_data_oe", data_oe[k], 0);
  endtask

  task automatic do_write(input int k, input logic [31:0] a, input logic [31:0] d, input bit disturb);
    logic m;
    int w, blen, wlo;
    logic [3:0] idx;
    m = is_mapped(k, a);
    w = WES[k];
    idx = widx(k, a);
    cur_k = k;
    @(negedge clk);
    addr[k] = a;
    data_in[k] = d;
    is_write[k] = 1'b1;
    #4;
    chk("req_busy", busy[k], m);
    if (!m) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        #4;
        chk("drop_busy", busy[k], 0);
        chk("drop_we_n", we_n[k], 1);
        chk("drop_data_oe", data_oe[k], 0);
      end
      is_write[k] = 1'b0;
      return;
    end
    blen = 1;
    wlo = 0;
    for (int c = 1; c <= w + 2; c++) begin
      @(negedge clk);
      if (disturb) begin
        addr[k] = c[0] ? 32'h100 : BASES[k] + 32'h3C;
        is_write[k] = 1'b1;
        data_in[k] = $urandom;
      end else begin
        is_write[k] = 1'b0;
      end
      #4;
      if (busy[k]) blen++;
      if (!we_n[k]) wlo++;
      chk("wr_we_n", we_n[k], (c >= 2 && c <= w + 1) ? 0 : 1);
      chk("wr_addr", 32'(sram_addr[k]), 32'(idx));
      chk("wr_dout", sram_dout[k], d);
      chk("wr_data_oe", data_oe[k], 1);
      chk("wr_ce_n", ce_n[k], 0);
      chk("wr_oe_n", oe_n[k], 1);
      chk("wr_data_out", data_out[k], 0);
    end
    @(negedge clk);
    is_write[k] = 1'b0;
    addr[k] = a;
    #4;
    if (busy[k]) blen++;
    chk("wr_busy_len", blen, w + 3);
    chk("wr_we_len", wlo, w);
    chk("end_we_n", we_n[k], 1);
    chk("end_data_oe", data_oe[k], 0);
    ref_mem[k][idx] = d;
  endtask

  task automatic reset_mid_write(input int k, input logic [31:0] a, input logic [31:0] d);
    cur_k = k;
    @(negedge clk);
    addr[k] = a;
    data_in[k] = d;
    is_write[k] = 1'b1;
    @(negedge clk);
    is_write[k] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #4;
    chk("pre_rst_we_n", we_n[k], 0);
    @(negedge clk);
    rst = 1'b0;
    #4;
    chk("rst_busy", busy[k], 0);
    chk("rst_we_n", we_n[k], 1);
    chk("rst_data_oe", data_oe[k], 0);
    chk("rst_ce_n", ce_n[k], 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog inst=%0d got=timeout exp=finish", cur_k);
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < 16; i++) ref_mem[k][i] = $urandom | 32'h1;
      addr[k] = 32'h0;
      data_in[k] = 32'h0;
      is_write[k] = 1'b0;
    end
    ref_mem[0][5] = 32'hDEADBEEF;
    rst = 1'b1;
    load = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    load = 1'b0;
    #4;
    for (int k = 0; k < N; k++) begin
      cur_k = k;
      chk("reset_busy", busy[k], 0);
      chk("reset_we_n", we_n[k], 1);
      chk("reset_data_oe", data_oe[k], 0);
    end

    do_read(0, 32'h14);
    do_write(0, 32'h8, 32'h12345678, 0);
    do_read(0, 32'h8);
    do_read(0, 32'h40);
    do_write(0, 32'h40, 32'hCAFEF00D, 0);
    do_write(0, 32'h20, 32'hA1B2C3D4, 1);
    do_read(0, 32'h20);
    do_read(0, 32'h3C);
    reset_mid_write(0, 32'hC, 32'h55AA55AA);
    do_write(0, 32'hC, 32'h0BADF00D, 0);
    do_read(0, 32'hC);

    do_write(1, 32'h44, 32'h11112222, 0);
    do_read(1, 32'h44);
    do_read(1, 32'h3C);
    do_write(1, 32'h80, 32'h33334444, 0);
    do_write(2, 32'h3F, 32'h55556666, 0);
    do_read(2, 32'h3C);

    for (int k = 0; k < N; k++) begin
      for (int n = 0; n < 40; n++) begin
        a = ($urandom_range(0, 9) < 7) ? BASES[k] + 32'($urandom_range(0, 63))
                                       : 32'($urandom_range(0, 255));
        case ($urandom_range(0, 2))
          0: do_read(k, a);
          1: do_write(k, a, $urandom, 0);
          default: do_write(k, a, $urandom, 1);
        endcase
      end
      for (int i = 0; i < 16; i++) do_read(k, BASES[k] + 32'(i * 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
